ibex_fetch_fifo: RTL and testbench

Instruction-fetch FIFO sitting between the instruction-bus request logic and the IF stage's compressed decoder. It buffers 32-bit words returned on the bus and realigns them into instructions at halfword granularity, so a 32-bit instruction straddling two words is presented as one item. It tags each instruction with its PC and fetch-error flags, and flushes on every PC change (branch, jump, exception, return).

---
 rtl/ibex_fetch_fifo.sv | 147 ++++++++++++++
 tb/tb_ibex_fetch_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_fifo.sv
// Instruction-fetch FIFO: buffers bus words and realigns them into halfword-aligned
// instructions (compressed or 32-bit) tagged with their PC and fetch-error flags.
module ibex_fetch_fifo #(
   parameter int unsigned NUM_REQS = 2,
   localparam int unsigned DEPTH = NUM_REQS + 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic [31:0]                  in_addr_i,
   input  logic                         in_valid_i,
   input  logic [31:0]                  in_rdata_i,
   input  logic                         in_err_i,
   output logic [$clog2(DEPTH+1)-1:0]   free_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [31:0]                  out_rdata_o,
   output logic [31:0]                  out_addr_o,
   output logic                         out_err_o,
   output logic                         out_err_plus2_o
);

   localparam int FW = $clog2(DEPTH + 1);

   logic [31:0]      rdata_q [DEPTH];
   logic [DEPTH-1:0] err_q;
   logic [DEPTH-1:0] valid_q;
   logic [31:0]      addr_q;

   logic [31:0]      w0_data;
   logic [15:0]      w1_lo;
   logic             w0_valid, w0_err, w1_valid, w1_err;
   logic             unaligned, is_comp, valid_raw, fire, pop;
   logic [15:0]      lo_half;

   logic [31:0]      nxt_data [DEPTH];
   logic [DEPTH-1:0] nxt_err, nxt_valid;
   logic [FW-1:0]    occupied;

   // Word k is entry k when stored, otherwise the incoming bus word for the first free slot.
   always_comb begin
      w0_valid = valid_q[0] | in_valid_i;
      w0_data  = (valid_q[0] | ~in_valid_i) ? rdata_q[0] : in_rdata_i;
      w0_err   = valid_q[0] ? err_q[0] : (in_valid_i & in_err_i);
      w1_valid = valid_q[1] | (valid_q[0] & in_valid_i);
      w1_lo    = (valid_q[1] | ~w1_valid) ? rdata_q[1][15:0] : in_rdata_i[15:0];
      w1_err   = valid_q[1] ? err_q[1] : (w1_valid & in_err_i);
   end

   always_comb begin
      unaligned = addr_q[1];
      lo_half   = unaligned ? w0_data[31:16] : w0_data[15:0];
      is_comp   = lo_half[1:0] != 2'b11;
      if (!unaligned) begin
         valid_raw       = w0_valid;
         out_rdata_o     = w0_data;
         out_err_o       = w0_err;
         out_err_plus2_o = 1'b0;
      end else begin
         out_rdata_o = {w1_lo, w0_data[31:16]};
         if (is_comp || w0_err) begin
            valid_raw       = w0_valid;
            out_err_o       = w0_err;
            out_err_plus2_o = 1'b0;
         end else begin
            valid_raw       = w0_valid & w1_valid;
            out_err_o       = w1_err;
            out_err_plus2_o = w1_err;
         end
      end
      out_valid_o = valid_raw & ~clear_i;
      out_addr_o  = addr_q;
      fire        = out_valid_o & out_ready_i;
      // Only an aligned compressed instruction leaves part of the head word unconsumed.
      pop         = fire & (unaligned | ~is_comp);
   end

   // Write into the first free slot (slot DEPTH exists only for push-while-full), then shift on pop.
   always_comb begin
      logic [31:0]  ext_data [DEPTH+1];
      logic [DEPTH:0] ext_err, ext_valid;
      logic prev;
      for (int i = 0; i < DEPTH; i++) begin
         ext_data[i]  = rdata_q[i];
         ext_err[i]   = err_q[i];
         ext_valid[i] = valid_q[i];
      end
      ext_data[DEPTH]  = '0;
      ext_err[DEPTH]   = 1'b0;
      ext_valid[DEPTH] = 1'b0;
      prev = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         if (in_valid_i && prev && !ext_valid[i]) begin
            ext_data[i]  = in_rdata_i;
            ext_err[i]   = in_err_i;
            ext_valid[i] = 1'b1;
            prev         = 1'b0;
         end else begin
            prev = ext_valid[i];
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         nxt_data[i]  = pop ? ext_data[i+1]  : ext_data[i];
         nxt_err[i]   = pop ? ext_err[i+1]   : ext_err[i];
         nxt_valid[i] = pop ? ext_valid[i+1] : ext_valid[i];
      end
   end

   always_comb begin
      occupied = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupied = occupied + FW'(valid_q[i]);
      end
      free_o = FW'(DEPTH) - occupied;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         err_q   <= '0;
         addr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rdata_q[i] <= '0;
         end
      end else if (clear_i) begin
         valid_q <= '0;
         addr_q  <= in_addr_i;
      end else begin
         valid_q <= nxt_valid;
         err_q   <= nxt_err;
         for (int i = 0; i < DEPTH; i++) begin
            rdata_q[i] <= nxt_data[i];
         end
         if (fire) begin
            addr_q <= addr_q + (is_comp ? 32'd2 : 32'd4);
         end
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !clear_i && free_o == '0) |-> pop);
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      clear_i |-> !in_addr_i[0]);
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_valid_o |-> !$isunknown({out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o}));

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
// Bench for ibex_fetch_fifo: a halfword-stream model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ibex_fetch_fifo;

   localparam int DEPTH = 3;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_i = 1'b0;
   logic [31:0] in_addr_i = '0;
   logic        in_valid_i = 1'b0;
   logic [31:0] in_rdata_i = '0;
   logic        in_err_i = 1'b0;
   logic        out_ready_i = 1'b0;
   logic [1:0]  free_o;
   logic        out_valid_o;
   logic [31:0] out_rdata_o;
   logic [31:0] out_addr_o;
   logic        out_err_o;
   logic        out_err_plus2_o;

   int n_checks = 0;
   int n_fail   = 0;

   ibex_fetch_fifo #(.NUM_REQS(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_n), .clear_i(clear_i), .in_addr_i(in_addr_i),
      .in_valid_i(in_valid_i), .in_rdata_i(in_rdata_i), .in_err_i(in_err_i),
      .free_o(free_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_rdata_o(out_rdata_o), .out_addr_o(out_addr_o), .out_err_o(out_err_o),
      .out_err_plus2_o(out_err_plus2_o)
   );

   always #5 clk_i = ~clk_i;

   // The model sees the fetch stream as a queue of halfwords starting at m_addr.
   typedef struct packed {
      logic [15:0] h;
      logic        e;
   } half_t;
   typedef half_t hq_t[$];

   typedef struct packed {
      logic        valid;
      logic        full32;
      logic [31:0] rdata;
      logic        err;
      logic        plus2;
      logic        comp;
      int          nhalf;
   } exp_t;

   hq_t         hq;
   logic [31:0] m_addr = '0;

   function automatic hq_t make_view(hq_t q, logic [31:0] a, logic v, logic [31:0] d, logic e);
      hq_t r = q;
      if (v) begin
         if (!(r.size() == 0 && a[1])) r.push_back('{d[15:0], e});
         r.push_back('{d[31:16], e});
      end
      return r;
   endfunction

   function automatic exp_t predict(hq_t v, logic clr);
      exp_t x = '0;
      if (!clr && v.size() >= 1) begin
         x.comp = v[0].h[1:0] != 2'b11;
         if (x.comp) begin
            x.valid = 1'b1; x.rdata = {16'h0, v[0].h}; x.err = v[0].e; x.nhalf = 1;
         end else if (v[0].e) begin
            x.valid = 1'b1; x.rdata = {16'h0, v[0].h}; x.err = 1'b1; x.nhalf = 2;
         end else if (v.size() >= 2) begin
            x.valid = 1'b1; x.full32 = 1'b1; x.rdata = {v[1].h, v[0].h};
            x.err = v[1].e; x.plus2 = v[1].e; x.nhalf = 2;
         end
      end
      return x;
   endfunction

   function automatic int model_free(int size, logic [31:0] a);
      return DEPTH - (size + int'(a[1])) / 2;
   endfunction

   always @(posedge clk_i or negedge rst_n) begin
      hq_t  v;
      exp_t x;
      if (!rst_n) begin
         hq.delete();
         m_addr = '0;
      end else if (clear_i) begin
         hq.delete();
         m_addr = in_addr_i;
      end else begin
         v = make_view(hq, m_addr, in_valid_i, in_rdata_i, in_err_i);
         x = predict(v, 1'b0);
         if (x.valid && out_ready_i) begin
            for (int i = 0; i < x.nhalf && v.size() > 0; i++) void'(v.pop_front());
            m_addr = m_addr + (x.comp ? 32'd2 : 32'd4);
         end
         hq = v;
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, compare the DUT with the model's view of stored plus in-flight halfwords.
   always @(negedge clk_i) begin
      exp_t x;
      x = predict(make_view(hq, m_addr, in_valid_i, in_rdata_i, in_err_i), clear_i);
      check_output("model valid", 32'(out_valid_o), 32'(x.valid));
      check_output("model addr", out_addr_o, m_addr);
      check_output("model free", 32'(free_o), 32'(model_free(hq.size(), m_addr)));
      if (x.valid) begin
         check_output("model err", 32'(out_err_o), 32'(x.err));
         check_output("model err_plus2", 32'(out_err_plus2_o), 32'(x.plus2));
         if (x.full32) check_output("model rdata", out_rdata_o, x.rdata);
         else          check_output("model rdata16", 32'(out_rdata_o[15:0]), x.rdata);
      end
   end

   task automatic apply_stimulus(input logic clr, input logic [31:0] addr, input logic vld,
                                 input logic [31:0] data, input logic err, input logic rdy);
      @(posedge clk_i);
      #1;
      clear_i     = clr;
      in_addr_i   = addr;
      in_valid_i  = vld;
      in_rdata_i  = data;
      in_err_i    = err;
      out_ready_i = rdy;
      @(negedge clk_i);
      #1;
   endtask

   initial begin
      #3;
      check_output("reset valid", 32'(out_valid_o), 32'd0);
      check_output("reset free", 32'(free_o), 32'd3);
      check_output("reset rdata", out_rdata_o, 32'd0);
      check_output("reset addr", out_addr_o, 32'd0);
      check_output("reset err", 32'(out_err_o), 32'd0);
      @(negedge clk_i);
      #2 rst_n = 1'b1;

      // Bypass of an aligned 32-bit word
      apply_stimulus(1, 32'h80, 0, 0, 0, 0);
      check_output("clear no valid", 32'(out_valid_o), 32'd0);
      apply_stimulus(0, 0, 1, 32'h0000_0013, 0, 1);
      check_output("bypass valid", 32'(out_valid_o), 32'd1);
      check_output("bypass rdata", out_rdata_o, 32'h0000_0013);
      check_output("bypass addr", out_addr_o, 32'h80);
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("bypass next addr", out_addr_o, 32'h84);
      check_output("bypass free", 32'(free_o), 32'd3);

      // Two compressed instructions in one word
      apply_stimulus(1, 32'h80, 0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 32'h4501_4501, 0, 1);
      check_output("pair first", 32'(out_rdata_o[15:0]), 32'h4501);
      apply_stimulus(0, 0, 0, 0, 0, 1);
      check_output("pair stored free", 32'(free_o), 32'd2);
      check_output("pair second addr", out_addr_o, 32'h82);
      check_output("pair second", 32'(out_rdata_o[15:0]), 32'h4501);
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("pair popped free", 32'(free_o), 32'd3);
      check_output("pair end addr", out_addr_o, 32'h84);

      // Straddling 32-bit instruction at 0x82
      apply_stimulus(1, 32'h80, 0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 32'h0093_4501, 0, 1);
      check_output("straddle comp", 32'(out_rdata_o[15:0]), 32'h4501);
      apply_stimulus(0, 0, 0, 0, 0, 1);
      check_output("straddle waits", 32'(out_valid_o), 32'd0);
      check_output("straddle addr", out_addr_o, 32'h82);
      apply_stimulus(0, 0, 1, 32'h0000_0093, 0, 0);
      check_output("straddle valid", 32'(out_valid_o), 32'd1);
      check_output("straddle rdata", out_rdata_o, 32'h0093_0093);
      apply_stimulus(0, 0, 0, 0, 0, 1);
      check_output("straddle free", 32'(free_o), 32'd1);
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("straddle next addr", out_addr_o, 32'h86);
      check_output("straddle pop one", 32'(free_o), 32'd2);

      // Error flags on straddles
      apply_stimulus(1, 32'h82, 0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 32'h0093_0000, 0, 0);
      check_output("err wait", 32'(out_valid_o), 32'd0);
      apply_stimulus(0, 0, 1, 32'h0000_0013, 1, 0);
      check_output("err2 rdata", out_rdata_o, 32'h0013_0093);
      check_output("err2 err", 32'(out_err_o), 32'd1);
      check_output("err2 plus2", 32'(out_err_plus2_o), 32'd1);
      apply_stimulus(1, 32'h82, 0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 32'h0093_0000, 1, 0);
      check_output("err1 valid", 32'(out_valid_o), 32'd1);
      check_output("err1 err", 32'(out_err_o), 32'd1);
      check_output("err1 plus2", 32'(out_err_plus2_o), 32'd0);

      // Fill, then push and pop together while full
      apply_stimulus(1, 32'h80, 0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 32'h0000_0013, 0, 0);
      apply_stimulus(0, 0, 1, 32'h0010_0093, 0, 0);
      apply_stimulus(0, 0, 1, 32'h0020_0113, 0, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("full free", 32'(free_o), 32'd0);
      check_output("full head", out_rdata_o, 32'h0000_0013);
      apply_stimulus(0, 0, 1, 32'h0030_0193, 0, 1);
      check_output("full pushpop free", 32'(free_o), 32'd0);
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("full after free", 32'(free_o), 32'd0);
      check_output("full after head", out_rdata_o, 32'h0010_0093);
      check_output("full after addr", out_addr_o, 32'h84);

      // Flush while full discards the concurrent word
      apply_stimulus(1, 32'h100, 1, 32'hdead_beef, 0, 1);
      check_output("flush valid", 32'(out_valid_o), 32'd0);
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("flush free", 32'(free_o), 32'd3);
      check_output("flush addr", out_addr_o, 32'h100);
      check_output("flush empty", 32'(out_valid_o), 32'd0);
      apply_stimulus(0, 0, 1, 32'h0000_0013, 0, 0);
      check_output("flush new word", out_rdata_o, 32'h0000_0013);
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("pre-reset free", 32'(free_o), 32'd2);

      // Asynchronous reset between clock edges
      #1 rst_n = 1'b0;
      #1;
      check_output("async reset valid", 32'(out_valid_o), 32'd0);
      check_output("async reset free", 32'(free_o), 32'd3);
      check_output("async reset addr", out_addr_o, 32'd0);
      @(negedge clk_i);
      #2 rst_n = 1'b1;
      apply_stimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
